// File: rtl/asteroid_pkg.sv
// Shared types and helpers for the asteroid_field block.
//   state_t    : game FSM states
//   LFSR_TAPS  : Galois feedback mask for the 16-bit spawn LFSR
//   lfsr_step  : one right-shift Galois step
//   fidx       : flat field index of (row, lane)
package asteroid_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
  endfunction

  function automatic int fidx(input int r, input int l, input int lanes);
    return r * lanes + l;
  endfunction
endpackage

// File: rtl/asteroid_field_lfsr16.sv
// Free-running 16-bit Galois LFSR, advanced once per enable cycle.
//   cin    : clock
//   resetn : async active-low reset, loads SEED
//   en     : advance enable (the game tick)
//   q      : current LFSR state
module lfsr16
  import asteroid_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        cin,
  input  logic        resetn,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge cin or negedge resetn) begin
    if (!resetn)  q <= SEED;
    else if (en)  q <= lfsr_step(q);
  end
endmodule

// File: rtl/asteroid_field.sv
// Falling-asteroid playfield: LANES x ROWS occupancy grid shifted down one
// row per tick, random single-asteroid spawns into row 0, collision check
// against the player in the bottom row and a saturating dodge score.
//   cin, resetn  : clock, async active-low reset
//   tick         : advance pulse (every high cycle is a tick)
//   start        : begin / restart game (level)
//   player_lane  : player's lane in the bottom row
//   field        : grid, bit r*LANES+l = asteroid at row r, lane l
//   score        : asteroids dodged, saturating
//   game_over    : high in OVER
//   hit          : one-cycle pulse on collision
module asteroid_field
  import asteroid_pkg::*;
#(
  parameter int          LANES    = 4,
  parameter int          ROWS     = 8,
  parameter int          SCORE_W  = 8,
  parameter int          SPAWN_TH = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  localparam int         LW       = $clog2(LANES)
) (
  input  logic                  cin,
  input  logic                  resetn,
  input  logic                  tick,
  input  logic                  start,
  input  logic [LW-1:0]         player_lane,
  output logic [LANES*ROWS-1:0] field,
  output logic [SCORE_W-1:0]    score,
  output logic                  game_over,
  output logic                  hit
);
  localparam int BOT = fidx(ROWS - 1, 0, LANES);
  // adder wide enough for both the score and a full-row popcount
  localparam int AW  = ((SCORE_W > LW) ? SCORE_W : LW) + 1;
  localparam logic [AW:0] SMAX = (AW+1)'({SCORE_W{1'b1}});
  localparam logic [4:0]  TH   = SPAWN_TH[4:0];

  state_t            st;
  logic [15:0]       lq, ln;
  logic [LANES-1:0]  bot, new_row;
  logic [AW-1:0]     pc;
  logic [AW:0]       sum;
  logic              collide;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .cin    (cin),
    .resetn (resetn),
    .en     (tick),
    .q      (lq)
  );

  // spawn decision uses the value the LFSR takes on this tick
  assign ln      = lfsr_step(lq);
  assign bot     = field[BOT +: LANES];
  assign collide = bot[player_lane];

  always_comb begin
    new_row = '0;
    if ({1'b0, ln[3:0]} < TH) new_row[ln[4 +: LW]] = 1'b1;
  end

  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) pc = pc + AW'(bot[i]);
    sum = (AW+1)'(score) + (AW+1)'(pc);
  end

  always_ff @(posedge cin or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      field     <= '0;
      score     <= '0;
      game_over <= 1'b0;
      hit       <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (st)
        IDLE: if (start) begin
          st    <= RUN;
          field <= '0;
          score <= '0;
        end
        RUN: begin
          // collision has priority over a same-cycle tick: grid and score freeze
          if (collide) begin
            hit       <= 1'b1;
            game_over <= 1'b1;
            st        <= OVER;
          end else if (tick) begin
            score <= (sum > SMAX) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
            field <= {field[BOT-1:0], new_row};
          end
        end
        OVER: if (start) begin
          st        <= RUN;
          field     <= '0;
          score     <= '0;
          game_over <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_asteroid_field.sv
module tb_asteroid_field;
  logic        cin = 1'b0;
  logic        resetn;
  logic        tick, start;
  logic [1:0]  player_lane;
  logic [31:0] field, field2;
  logic [7:0]  score;
  logic [1:0]  score2;
  logic        game_over, game_over2, hit, hit2;

  always #10 cin = ~cin;

  asteroid_field dut (
    .cin(cin), .resetn(resetn), .tick(tick), .start(start),
    .player_lane(player_lane), .field(field), .score(score),
    .game_over(game_over), .hit(hit)
  );

  asteroid_field #(.SCORE_W(2)) dut2 (
    .cin(cin), .resetn(resetn), .tick(tick), .start(start),
    .player_lane(player_lane), .field(field2), .score(score2),
    .game_over(game_over2), .hit(hit2)
  );

  typedef struct {
    logic [31:0] fld;
    logic [7:0]  sc;
    logic [1:0]  sc2;
    logic        go;
    logic        hit;
    logic [15:0] lf;
  } exp_t;

  exp_t sbq[$];

  int nvec = 0, nmis = 0;

  // reference model state
  int          m_st;
  logic [31:0] m_fld;
  int          m_sc, m_sc2;
  logic        m_go;
  logic [15:0] m_lf;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    logic [15:0] r;
    r = l >> 1;
    if (l[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [1:0] safe_lane();
    for (int l = 0; l < 4; l++)
      if (!m_fld[28+l]) return 2'(l);
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_fld = '0; m_sc = 0; m_sc2 = 0; m_go = 1'b0; m_lf = 16'hACE1;
  endtask

  // drive one cycle, push model expectation, compare after the edge
  task automatic step(input logic st, input logic tk, input logic [1:0] ln);
    exp_t        e, g;
    logic [15:0] nl;
    logic [3:0]  bt, nr;
    int          pcnt;
    start = st; tick = tk; player_lane = ln;
    nl = tk ? lstep(m_lf) : m_lf;
    e.hit = 1'b0;
    bt = m_fld[31:28];
    case (m_st)
      0: if (st) begin m_st = 1; m_fld = '0; m_sc = 0; m_sc2 = 0; end
      1: if (bt[ln]) begin
           e.hit = 1'b1; m_st = 2; m_go = 1'b1;
         end else if (tk) begin
           pcnt = int'(bt[0]) + int'(bt[1]) + int'(bt[2]) + int'(bt[3]);
           m_sc  = (m_sc + pcnt > 255) ? 255 : m_sc + pcnt;
           m_sc2 = (m_sc2 + pcnt > 3) ? 3 : m_sc2 + pcnt;
           nr = '0;
           if (nl[3:0] < 4'd8) nr[nl[5:4]] = 1'b1;
           m_fld = {m_fld[27:0], nr};
         end
      default: if (st) begin m_st = 1; m_fld = '0; m_sc = 0; m_sc2 = 0; m_go = 1'b0; end
    endcase
    m_lf = nl;
    e.fld = m_fld; e.sc = 8'(m_sc); e.sc2 = 2'(m_sc2); e.go = m_go; e.lf = m_lf;
    sbq.push_back(e);
    @(posedge cin); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 64'd0, 64'd1);
    end else begin
      g = sbq.pop_front();
      chk("field", field, g.fld);
      chk("field2", field2, g.fld);
      chk("score", score, g.sc);
      chk("score2", score2, g.sc2);
      chk("game_over", game_over, g.go);
      chk("hit", hit, g.hit);
      chk("hit2", hit2, g.hit);
      chk("lfsr", dut.u_lfsr.q, g.lf);
    end
  endtask

  initial begin
    logic [31:0] sv_fld;
    logic [7:0]  sv_sc;
    logic [3:0]  bt;
    logic [1:0]  cl;
    int          n;
    resetn = 1'b0; start = 1'b0; tick = 1'b0; player_lane = 2'd0;
    model_reset();
    repeat (2) @(posedge cin);
    #1;
    chk("rst_field", field, 32'd0);
    chk("rst_score", score, 8'd0);
    chk("rst_go", game_over, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    resetn = 1'b1;

    step(1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    // first spawn
    step(1'b0, 1'b1, 2'd0);
    chk("spawn_lfsr", dut.u_lfsr.q, 16'hE270);
    chk("spawn_field", field, 32'h0000_0008);

    // eight dodging ticks: first asteroid scored and gone
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, safe_lane());
    chk("dodge_score", score, 8'd1);
    chk("dodge_go", game_over, 1'b0);

    // dodge until something sits in the bottom row, with some idle cycles
    n = 0;
    while (m_fld[31:28] == 4'd0 && n < 200) begin
      step(1'b0, (n % 3) != 2, safe_lane());
      n++;
    end
    bt = field[31:28];
    if (bt == 4'd0) begin
      chk("bottom_timeout", 64'd0, 64'd1);
    end else begin
      cl = bt[0] ? 2'd0 : bt[1] ? 2'd1 : bt[2] ? 2'd2 : 2'd3;
      sv_fld = field; sv_sc = score;
      // move under the asteroid with tick high: collision must win
      step(1'b0, 1'b1, cl);
      chk("col_hit", hit, 1'b1);
      chk("col_go", game_over, 1'b1);
      chk("col_field", field, sv_fld);
      chk("col_score", score, sv_sc);
      step(1'b0, 1'b1, cl);
      chk("col_hit_pulse", hit, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd0);
      chk("over_field", field, sv_fld);
    end

    // restart from OVER
    step(1'b1, 1'b0, 2'd0);
    chk("restart_field", field, 32'd0);
    chk("restart_score", score, 8'd0);
    chk("restart_go", game_over, 1'b0);

    // long dodge run drives the 2-bit score into saturation
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, safe_lane());
    chk("sat_score2", score2, 2'd3);

    // async reset mid-RUN, checked between clock edges
    #4 resetn = 1'b0;
    #1;
    chk("arst_field", field, 32'd0);
    chk("arst_score", score, 8'd0);
    chk("arst_go", game_over, 1'b0);
    chk("arst_hit", hit, 1'b0);
    chk("arst_lfsr", dut.u_lfsr.q, 16'hACE1);
    model_reset();
    sbq.delete();
    @(posedge cin); #1;
    resetn = 1'b1;
    step(1'b0, 1'b1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
